// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, error causes,
// FSM state encoding and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Encodings the LSU cannot execute are reported as misaligned, which
  // lets the decoder use a single error path.
  function automatic logic f3_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:         bad = 1'b0;
      F3_H:         bad = lo[0];
      F3_W:         bad = (lo != 2'b00);
      F3_BU, F3_HU: bad = we | ((f3 == F3_HU) & lo[0]);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: load extraction with sign/zero extension and
// sub-word merge of store data into an existing memory word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  // Load result: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Store merge: overwrite only the addressed lane of the old word.
  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B:    merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, sub-word stores as read-modify-write,
// misaligned/out-of-range requests answered with an error and no memory access.
module lsu
  import lsu_pkg::*;
#(
  parameter int WORD_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_op,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic [1:0]  rsp_cause_q;

  logic        misalign_d;
  logic        range_d;
  logic [1:0]  cause_d;
  logic [31:0] load_ext;
  logic [31:0] merged;

  lsu_lane u_lane (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (mem_rdata),
    .wdata_i   (wdata_q),
    .load_o    (load_ext),
    .merge_o   (merged)
  );

  // Classify the incoming request; misalignment wins over range.
  always_comb begin
    misalign_d = f3_misaligned(req_we, req_funct3, req_addr[1:0]);
    range_d    = ((req_addr >> (WORD_IDX_W + 2)) != 32'h0);
    cause_d    = CAUSE_NONE;
    if (misalign_d)   cause_d = CAUSE_MISALIGN;
    else if (range_d) cause_d = CAUSE_RANGE;
  end

  // Main sequencer: accept, access memory, hold the response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wbuf_q      <= 32'h0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q    <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= (cause_d != CAUSE_NONE);
            rsp_cause_q <= cause_d;
            if (cause_d != CAUSE_NONE) begin
              state_q <= ST_RESP;
            end else if (!req_we) begin
              state_q <= ST_LOAD;
            end else if (req_funct3 == F3_W) begin
              wbuf_q  <= req_wdata;
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_MERGE;
            end
          end
        end
        ST_LOAD: begin
          rsp_data_q <= load_ext;
          state_q    <= ST_RESP;
        end
        ST_MERGE: begin
          wbuf_q  <= merged;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign mem_op    = (state_q == ST_LOAD) || (state_q == ST_MERGE) || (state_q == ST_WRITE);
  assign mem_wr    = (state_q == ST_WRITE);
  assign mem_addr  = {2'b00, addr_q[31:2]};
  assign mem_wdata = wbuf_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_cause = rsp_cause_q;

endmodule
